alu_operand_loader: RTL
=======================

Name: alu_operand_loader

Overview:
- Producer side of the operand-gating interface in the 4-bit ALU datapath.
- Accepts operand nibbles one at a time over a valid/ready stream: first nibble is operand A, second is operand B.
- Presents both operands as scalar bits A3..A0 and B3..B0, and raises the gate enable D for a bounded window.
- Drops D when the downstream acknowledge arrives and the minimum hold has elapsed, then returns to accept the next operand pair.

Parameters:
- HOLD_CYCLES, 1, minimum number of cycles D stays high per operand pair; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand nibble valid.
- in_ready  output  1  loader can accept a nibble this cycle.
- in_data  input  4  operand nibble; bit 0 is LSB.
- abort  input  1  synchronous cancel of the current pair.
- opnd_ack  input  1  downstream has consumed the gated operands.
- D  output  1  operand gate enable.
- A3, A2, A1, A0  output  1 each  operand A bits.
- B3, B2, B1, B0  output  1 each  operand B bits.
- busy  output  1  high in any state other than LOAD_A.
- done  output  1  one-cycle pulse when a pair completes normally.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is LOAD_A.
  - D, done, busy and all of A3..A0 and B3..B0 are 0.
  - Hold counter and ack_seen are 0.
  - in_ready is 1 once rst_n is high.
- All outputs except in_ready are registered. in_ready = (state==LOAD_A or state==LOAD_B) and not abort.
- Transfer rule: a nibble transfers on a rising edge where in_valid and in_ready are both 1. in_data must be stable while in_valid is high. The loader never drops a nibble it has flagged ready for.
- LOAD_A: on transfer, capture in_data into A3..A0 and go to LOAD_B.
- LOAD_B: on transfer, capture in_data into B3..B0, load the counter with HOLD_CYCLES-1, clear ack_seen, set D=1, and go to DRIVE.
- DRIVE:
  - in_ready is 0 and D is 1.
  - Each cycle: if counter != 0, decrement it. If opnd_ack is 1, set ack_seen.
  - Exit at the edge where counter==0 and (opnd_ack or ack_seen). On exit: D goes to 0, done goes to 1 for one cycle, and the state returns to LOAD_A.
- Latency:
  - A accepted at edge 0, B at edge 1; D is high from edge 2.
  - With HOLD_CYCLES=1 and opnd_ack already high, D is high for exactly 1 cycle.
  - D is high for max(HOLD_CYCLES, k+1) cycles, where k is the DRIVE cycle index (0-based) of the first opnd_ack.
- Operand hold: A3..A0 and B3..B0 keep their values after D falls, until overwritten by a new transfer. Consumers qualify them with D.
- abort, highest priority:
  - At the next edge: go to LOAD_A, D=0, counter=0, ack_seen=0.
  - done is not pulsed.
  - A and B bits are unchanged.
  - A nibble presented in the same cycle is not accepted, because in_ready is forced to 0.
- opnd_ack outside DRIVE is ignored and is not remembered.
- Back-to-back operation: in_valid may be high in the cycle done pulses; that nibble is taken as the new A.
- Reset mid-DRIVE: D falls immediately (asynchronously) and done does not pulse.
- Counter width is 4 bits. It never wraps below 0.

Decomposition:
- Shared include alu_defs.vh holds:
  - state encodings LOAD_A=2'd0, LOAD_B=2'd1, DRIVE=2'd2 (2'd3 unused; decodes to LOAD_A);
  - operand width constant 4;
  - HOLD counter width 4.
- One sub-module: hold_timer. It contains the load/decrement counter plus the ack_seen latch and outputs expired_and_acked. The FSM and operand registers stay in the top.

Test Plan:
- Basic, HOLD_CYCLES=1, opnd_ack tied 1: send 4'hA then 4'h5 -> A3..A0=1010, B3..B0=0101, D high exactly 1 cycle starting 2 cycles after A accepted, done pulses once, in_ready low only during DRIVE.
- Minimum hold, HOLD_CYCLES=3: send 4'h3, 4'hC with opnd_ack high in the first DRIVE cycle only -> D high exactly 3 cycles (ack remembered), then done.
- Late ack, HOLD_CYCLES=2: opnd_ack first asserted on DRIVE cycle index 5 -> D high 6 cycles, done on the following cycle, no nibble accepted meanwhile.
- Abort: assert abort in LOAD_B with in_valid=1 and in_data=4'hF -> nibble not taken, state LOAD_A, B bits unchanged. Repeat with abort in DRIVE -> D low next edge, no done pulse.
- Backpressure and back-to-back: in_valid held high with stream 1,2,3,4 and ack tied 1 -> pairs (1,2) and (3,4) both gated, nibble 3 accepted in the done cycle, no nibble lost or duplicated.
- Async reset: pull rst_n low mid-DRIVE between clock edges -> D, done and all operand bits 0 immediately. After release, in_ready=1 and a fresh pair completes normally.

Source files
------------

// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: FSM states and datapath widths.
package alu_operand_loader_pkg;

    // Encoding 2'd3 is never entered; the FSM treats it as LOAD_A.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DRIVE  = 2'd2
    } state_e;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/alu_operand_loader_hold_timer.sv
// Minimum-hold counter plus acknowledge latch for the operand gate window.
module hold_timer
    import alu_operand_loader_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired_and_acked
);

    localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] cnt_d, cnt_q;
    logic              ack_seen_d, ack_seen_q;

    // Next counter / ack latch value: clear beats load beats run.
    always_comb begin
        cnt_d      = cnt_q;
        ack_seen_d = ack_seen_q;
        if (clear) begin
            cnt_d      = '0;
            ack_seen_d = 1'b0;
        end else if (load) begin
            cnt_d      = LOAD_VAL;
            ack_seen_d = 1'b0;
        end else if (run) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (ack) begin
                ack_seen_d = 1'b1;
            end
        end
    end

    // Counter and ack latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign expired_and_acked = (cnt_q == '0) && (ack || ack_seen_q);

endmodule

// File: rtl/alu_operand_loader.sv
// Operand loader: takes A then B nibbles over valid/ready, then drives the
// gate enable D until the hold time has elapsed and downstream has acked.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       abort,
    input  logic       opnd_ack,
    output logic       D,
    output logic       A3,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic       B3,
    output logic       B2,
    output logic       B1,
    output logic       B0,
    output logic       busy,
    output logic       done
);

    state_e            state_d, state_q;
    logic              d_d, d_q;
    logic              done_d, done_q;
    logic              busy_d, busy_q;
    logic [OPND_W-1:0] a_d, a_q;
    logic [OPND_W-1:0] b_d, b_q;

    logic tmr_load, tmr_clear, tmr_run, tmr_expired;
    logic xfer;

    // Ready in both load states (including the unused encoding) unless aborting.
    assign in_ready = (state_q != DRIVE) && !abort;
    assign xfer     = in_valid && in_ready;

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        done_d    = 1'b0;
        a_d       = a_q;
        b_d       = b_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_run   = 1'b0;
        if (abort) begin
            state_d   = LOAD_A;
            d_d       = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                LOAD_B: begin
                    if (xfer) begin
                        b_d      = in_data;
                        tmr_load = 1'b1;
                        d_d      = 1'b1;
                        state_d  = DRIVE;
                    end
                end
                DRIVE: begin
                    tmr_run = 1'b1;
                    if (tmr_expired) begin
                        d_d     = 1'b0;
                        done_d  = 1'b1;
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    if (xfer) begin
                        a_d     = in_data;
                        state_d = LOAD_B;
                    end
                end
            endcase
        end
        busy_d = (state_d != LOAD_A);
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            d_q     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (tmr_load),
        .clear            (tmr_clear),
        .run              (tmr_run),
        .ack              (opnd_ack),
        .expired_and_acked(tmr_expired)
    );

    assign D    = d_q;
    assign done = done_q;
    assign busy = busy_q;
    assign A3   = a_q[3];
    assign A2   = a_q[2];
    assign A1   = a_q[1];
    assign A0   = a_q[0];
    assign B3   = b_q[3];
    assign B2   = b_q[2];
    assign B1   = b_q[1];
    assign B0   = b_q[0];

endmodule
